// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
//   Bundles the two writeback requesters (A = ALU, M = memory/load) and the
//   register-file write port for regfile_write_arbiter.
//   master : requester side / register file side (drives valid/rd/data,
//            observes ready, RW/PW/LE and conflict_cnt)
//   slave  : the arbiter
//   Signals:
//     a_valid/a_rd/a_data/a_ready  ALU writeback handshake
//     m_valid/m_rd/m_data/m_ready  load writeback handshake
//     RW/PW/LE                     registered register-file write port
//     conflict_cnt                 saturating count of both-valid cycles
interface regfile_write_arbiter_if;
  logic        a_valid;
  logic [4:0]  a_rd;
  logic [31:0] a_data;
  logic        a_ready;
  logic        m_valid;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_ready;
  logic [4:0]  RW;
  logic [31:0] PW;
  logic        LE;
  logic [15:0] conflict_cnt;

  modport master (
    output a_valid, a_rd, a_data, m_valid, m_rd, m_data,
    input  a_ready, m_ready, RW, PW, LE, conflict_cnt
  );

  modport slave (
    input  a_valid, a_rd, a_data, m_valid, m_rd, m_data,
    output a_ready, m_ready, RW, PW, LE, conflict_cnt
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the register file's single write port between the ALU writeback
//   path (A) and the load writeback path (M). At most one requester is
//   granted per cycle; the winner's rd/data are registered onto RW/PW and LE
//   is raised unless rd is register 0 (handshake completes, write dropped).
//   Parameters:
//     FIXED_A_PRIO  0: round-robin on ties, 1: A wins ties unless M starved
//     MAX_WAIT      refusals of a pending M tolerated in fixed mode (1..15)
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset
//     bus    requester handshakes + registered write port (slave modport)
module regfile_write_arbiter #(
  parameter bit          FIXED_A_PRIO = 1'b0,
  parameter int unsigned MAX_WAIT     = 4
) (
  input logic                    clk,
  input logic                    reset,
  regfile_write_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_req_t;

  wr_req_t     req_a, req_m, win;
  logic        last_a;      // 1: A won the most recent tie, 0: M (reset)
  logic [3:0]  wait_cnt;    // consecutive refusals of a pending M
  logic        tie;
  logic        a_pref;
  logic        gnt_a, gnt_m;
  logic [4:0]  rw_q;
  logic [31:0] pw_q;
  logic        le_q;
  logic [15:0] cnt_q;

  assign req_a = '{valid: bus.a_valid, rd: bus.a_rd, data: bus.a_data};
  assign req_m = '{valid: bus.m_valid, rd: bus.m_rd, data: bus.m_data};
  assign tie   = req_a.valid & req_m.valid;

  // Grants depend only on valids and arbitration state, never on rd/data.
  always_comb begin
    a_pref = FIXED_A_PRIO ? (wait_cnt != MAX_W) : ~last_a;
    gnt_a  = ~reset & req_a.valid & (~req_m.valid | a_pref);
    gnt_m  = ~reset & req_m.valid & ~gnt_a;
    win    = gnt_a ? req_a : req_m;
  end

  assign bus.a_ready      = gnt_a;
  assign bus.m_ready      = gnt_m;
  assign bus.RW           = rw_q;
  assign bus.PW           = pw_q;
  assign bus.LE           = le_q;
  assign bus.conflict_cnt = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw_q     <= '0;
      pw_q     <= '0;
      le_q     <= 1'b0;
      cnt_q    <= '0;
      last_a   <= 1'b0;
      wait_cnt <= '0;
    end else begin
      // Write port: RW/PW hold when idle, LE is a one-cycle strobe.
      if (gnt_a | gnt_m) begin
        rw_q <= win.rd;
        pw_q <= win.data;
        le_q <= (win.rd != 5'd0);
      end else begin
        le_q <= 1'b0;
      end

      if (tie) begin
        if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        if (!FIXED_A_PRIO) last_a <= gnt_a;
      end

      // Starvation guard: only a pending-but-refused M accumulates.
      if (FIXED_A_PRIO && req_m.valid && !gnt_m)
        wait_cnt <= (wait_cnt == MAX_W) ? wait_cnt : wait_cnt + 4'd1;
      else
        wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        av, mv;
  logic [4:0]  ar, mr;
  logic [31:0] ad, md;

  regfile_write_arbiter_if if_rr();
  regfile_write_arbiter_if if_fx();

  assign if_rr.a_valid = av;  assign if_fx.a_valid = av;
  assign if_rr.a_rd    = ar;  assign if_fx.a_rd    = ar;
  assign if_rr.a_data  = ad;  assign if_fx.a_data  = ad;
  assign if_rr.m_valid = mv;  assign if_fx.m_valid = mv;
  assign if_rr.m_rd    = mr;  assign if_fx.m_rd    = mr;
  assign if_rr.m_data  = md;  assign if_fx.m_data  = md;

  regfile_write_arbiter #(.FIXED_A_PRIO(1'b0), .MAX_WAIT(4)) dut_rr (
    .clk(clk), .reset(reset), .bus(if_rr));
  regfile_write_arbiter #(.FIXED_A_PRIO(1'b1), .MAX_WAIT(4)) dut_fx (
    .clk(clk), .reset(reset), .bus(if_fx));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (index 0: round-robin, 1: fixed) ----
  bit          last_a [2];
  int          streak [2];
  int          cnt    [2];
  logic [4:0]  e_rw   [2];
  logic [31:0] e_pw   [2];
  bit          e_le   [2];

  // 0 none, 1 A, 2 M
  function automatic int pick(input int m, input bit a, input bit b, input bit la, input int st);
    if (!a && !b) return 0;
    if (!b) return 1;
    if (!a) return 2;
    if (m == 0) return la ? 2 : 1;
    return (st >= 4) ? 2 : 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        last_a[m] <= 1'b0; streak[m] <= 0; cnt[m] <= 0;
        e_rw[m] <= '0; e_pw[m] <= '0; e_le[m] <= 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        case (pick(m, av, mv, last_a[m], streak[m]))
          1: begin e_rw[m] <= ar; e_pw[m] <= ad; e_le[m] <= (ar != 0); end
          2: begin e_rw[m] <= mr; e_pw[m] <= md; e_le[m] <= (mr != 0); end
          default: e_le[m] <= 1'b0;
        endcase
        if (av && mv) begin
          cnt[m] <= (cnt[m] < 65535) ? cnt[m] + 1 : cnt[m];
          if (m == 0) last_a[m] <= (pick(m, av, mv, last_a[m], streak[m]) == 1);
        end
        streak[m] <= (mv && pick(m, av, mv, last_a[m], streak[m]) != 2) ? streak[m] + 1 : 0;
      end
    end
  end

  task automatic cmp(input int m, input logic ar_q, input logic mr_q, input logic [4:0] rw,
                     input logic [31:0] pw, input logic le, input logic [15:0] cc);
    int w;
    w = pick(m, av, mv, last_a[m], streak[m]);
    chk($sformatf("m%0d_a_ready", m), 32'(ar_q), 32'(w == 1));
    chk($sformatf("m%0d_m_ready", m), 32'(mr_q), 32'(w == 2));
    chk($sformatf("m%0d_RW", m), 32'(rw), 32'(e_rw[m]));
    chk($sformatf("m%0d_PW", m), pw, e_pw[m]);
    chk($sformatf("m%0d_LE", m), 32'(le), 32'(e_le[m]));
    chk($sformatf("m%0d_cnt", m), 32'(cc), 32'(cnt[m]));
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_ready_rr", 32'({if_rr.a_ready, if_rr.m_ready}), 32'd0);
      chk("rst_ready_fx", 32'({if_fx.a_ready, if_fx.m_ready}), 32'd0);
    end else begin
      cmp(0, if_rr.a_ready, if_rr.m_ready, if_rr.RW, if_rr.PW, if_rr.LE, if_rr.conflict_cnt);
      cmp(1, if_fx.a_ready, if_fx.m_ready, if_fx.RW, if_fx.PW, if_fx.LE, if_fx.conflict_cnt);
    end
  end

  // Register file fed by the round-robin instance's write port.
  logic [31:0] rf [32];
  always @(posedge clk) if (if_rr.LE) rf[if_rr.RW] <= if_rr.PW;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input string nm, input logic [4:0] rw_rr, input logic [31:0] pw_rr,
                    input logic [4:0] rw_fx, input logic [31:0] pw_fx);
    chk({nm, "_LE_rr"}, 32'(if_rr.LE), 32'd1);
    chk({nm, "_RW_rr"}, 32'(if_rr.RW), 32'(rw_rr));
    chk({nm, "_PW_rr"}, if_rr.PW, pw_rr);
    chk({nm, "_LE_fx"}, 32'(if_fx.LE), 32'd1);
    chk({nm, "_RW_fx"}, 32'(if_fx.RW), 32'(rw_fx));
    chk({nm, "_PW_fx"}, if_fx.PW, pw_fx);
  endtask

  task automatic enter_reset();
    @(negedge clk); #2; reset = 1'b1;
  endtask

  task automatic leave_reset();
    @(negedge clk); #2; reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    av = 0; ar = 0; ad = 0; mv = 0; mr = 0; md = 0;
    #3;
    chk("init_LE",  32'(if_rr.LE | if_fx.LE), 32'd0);
    chk("init_RW",  32'(if_rr.RW | if_fx.RW), 32'd0);
    chk("init_PW",  if_rr.PW | if_fx.PW, 32'd0);
    chk("init_cnt", 32'(if_rr.conflict_cnt | if_fx.conflict_cnt), 32'd0);
    leave_reset();

    // single requester stream
    av = 1; ar = 5; ad = 32'h11;
    step(); wr("s0", 5, 32'h11, 5, 32'h11);
    ar = 6; ad = 32'h22;
    step(); wr("s1", 6, 32'h22, 6, 32'h22);
    ar = 7; ad = 32'h33;
    step(); wr("s2", 7, 32'h33, 7, 32'h33);
    av = 0;
    step();
    chk("s_idle_LE", 32'(if_rr.LE), 32'd0);
    chk("s_idle_RW", 32'(if_rr.RW), 32'd7);

    // mid-cycle reset with a write in flight and A still requesting
    av = 1; ar = 12; ad = 32'h55;
    step(); wr("r_pre", 12, 32'h55, 12, 32'h55);
    enter_reset(); #1;
    chk("r_LE",      32'(if_rr.LE | if_fx.LE), 32'd0);
    chk("r_RW",      32'(if_rr.RW), 32'd0);
    chk("r_PW",      if_fx.PW, 32'd0);
    chk("r_a_ready", 32'(if_rr.a_ready | if_fx.a_ready), 32'd0);
    @(negedge clk); #1;
    chk("r_a_ready2", 32'(if_rr.a_ready | if_fx.a_ready), 32'd0);
    #1; reset = 1'b0;
    step(); wr("r_post", 12, 32'h55, 12, 32'h55);
    av = 0;

    // round-robin tie from reset
    enter_reset();
    av = 1; ar = 3; ad = 32'hAAAA; mv = 1; mr = 4; md = 32'hBBBB;
    leave_reset();
    step(); wr("t0", 3, 32'hAAAA, 3, 32'hAAAA);
    chk("t0_cnt", 32'(if_rr.conflict_cnt), 32'd1);
    av = 0;
    step(); wr("t1", 4, 32'hBBBB, 4, 32'hBBBB);
    chk("t1_cnt", 32'(if_rr.conflict_cnt), 32'd1);
    mv = 0;
    step();
    chk("t2_LE",  32'(if_rr.LE | if_fx.LE), 32'd0);
    chk("t2_cnt", 32'(if_fx.conflict_cnt), 32'd1);

    // continuous contention: fixed A,A,A,A,M ; round-robin alternates (A won last tie)
    av = 1; ar = 1; ad = 32'hA1; mv = 1; mr = 2; md = 32'hB2;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("sv_fx_%0d", i), 32'(if_fx.RW), (i % 5 == 4) ? 32'd2 : 32'd1);
      chk($sformatf("sv_rr_%0d", i), 32'(if_rr.RW), (i % 2 == 0) ? 32'd2 : 32'd1);
    end
    chk("sv_cnt", 32'(if_rr.conflict_cnt), 32'd11);
    av = 0; mv = 0;
    step();

    // register 0: handshake completes, no write
    mv = 1; mr = 0; md = 32'hDEADBEEF;
    #1;
    chk("z_m_ready", 32'(if_rr.m_ready & if_fx.m_ready), 32'd1);
    step();
    chk("z_LE", 32'(if_rr.LE | if_fx.LE), 32'd0);
    chk("z_PW", if_rr.PW, 32'hDEADBEEF);
    mv = 0;
    step();

    // same destination from both requesters
    enter_reset();
    av = 1; ar = 9; ad = 32'h1; mv = 1; mr = 9; md = 32'h2;
    leave_reset();
    step(); wr("d0", 9, 32'h1, 9, 32'h1);
    av = 0;
    step(); wr("d1", 9, 32'h2, 9, 32'h2);
    mv = 0;
    step();
    chk("d_rf9", rf[9], 32'h2);
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port (RW, PW, LE) between two writeback requesters: the ALU path (A) and the memory/load path (M). Each requester offers a destination register and 32-bit result over a valid/ready handshake. The block grants at most one requester per cycle and registers the winning write onto the register-file write port. Writes to register 0 are accepted but suppressed.

## Interface
- FIXED_A_PRIO, 0, 0 = round-robin between A and M; 1 = A always wins unless M is starved
- MAX_WAIT, 4, consecutive cycles M may be refused in fixed-priority mode before a forced M grant (range 1–15)
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- a_valid  input  1  A requests a write
- a_rd  input  5  A destination register
- a_data  input  32  A write data
- a_ready  output  1  A transfer accepted this cycle (combinational)
- m_valid  input  1  M requests a write
- m_rd  input  5  M destination register
- m_data  input  32  M write data
- m_ready  output  1  M transfer accepted this cycle (combinational)
- RW  output  5  register-file write select (registered)
- PW  output  32  register-file write data (registered)
- LE  output  1  register-file load enable (registered)
- conflict_cnt  output  16  count of cycles in which both requesters were valid; saturates at 16'hFFFF

## Operation
- A transfer occurs on a rising edge where x_valid && x_ready. The requester must hold valid, rd and data stable until it is accepted. The arbiter never drops a held request.
- The write port never back-pressures, so a grant is issued every cycle in which any request is valid. a_ready and m_ready are never both 1.
- Only one requester valid: that requester is granted.
- Both valid, FIXED_A_PRIO=0: grant the requester other than `last`, then update `last` to the winner. `last` resets to M, so A wins the first tie.
- Both valid, FIXED_A_PRIO=1: grant A, unless wait_cnt == MAX_WAIT, in which case grant M.
- wait_cnt (4-bit, used only in fixed mode):
  - Increments when m_valid is set and M is refused.
  - Clears when M is granted or m_valid is 0.
  - Never exceeds MAX_WAIT.
- Output stage:
  - On a transfer, load RW ← rd and PW ← data.
  - LE ← 1 only if rd != 0. A transfer with rd == 0 completes its handshake but produces LE = 0.
  - With no transfer, LE ← 0. RW and PW hold their previous values.
- Same rd from A and M in the same cycle: each is written in grant order, so the later-granted write wins in the register file. The block does not reorder or merge writes.
- conflict_cnt increments on every edge where a_valid && m_valid, and stops at 16'hFFFF.

## Timing
- Reset (asynchronous, takes effect immediately): RW=0, PW=0, LE=0, conflict_cnt=0, `last`=M, wait_cnt=0.
- While reset is high, a_ready=0 and m_ready=0 regardless of the valid inputs.
- A write that is in flight (LE=1) when reset asserts is lost.
- The first grant is possible on the first rising edge after reset deasserts.
- Latency: a request accepted at edge k drives RW/PW/LE during cycle k+1, and the register file captures it at edge k+1.
- Throughput: one write per cycle. Back-to-back grants to the same requester are allowed when only it is valid.
- Ready paths are combinational from the valid inputs and internal state only. There is no combinational path from data or rd to the ready outputs.

## Test plan
- **Reset:** assert reset mid-cycle while a_valid=1.
  - Required: outputs go to 0 immediately; a_ready=0 until reset drops.
  - Required: the first edge after release gives LE=1, RW=a_rd.
- **Single requester stream:** a_valid=1 for 3 cycles with rd 5, 6, 7 and data 0x11, 0x22, 0x33.
  - Required: LE=1 for 3 consecutive cycles, with RW/PW = 5/0x11, 6/0x22, 7/0x33, each one cycle after acceptance.
- **Round-robin tie:** FIXED_A_PRIO=0; A(rd 3, 0xAAAA) and M(rd 4, 0xBBBB) held valid from reset.
  - Required: the first write is RW=3, the second is RW=4.
  - Required: conflict_cnt=1 after the first edge; it stops incrementing after the second edge because A has dropped valid.
- **Starvation guard:** FIXED_A_PRIO=1, MAX_WAIT=4; a_valid and m_valid held continuously.
  - Required: the grant pattern is A, A, A, A, M, then repeats.
- **Register 0:** m_rd=0, m_data=0xDEADBEEF, m_valid=1 for one cycle.
  - Required: m_ready=1 and LE=0 in the following cycle.
- **Same destination:** A and M both target rd 9 (A=0x1, M=0x2), FIXED_A_PRIO=0 from reset.
  - Required: RW=9, PW=0x1, then RW=9, PW=0x2; the final register-file value is 0x2.
